// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types for the instruction fetch controller: instruction word layout
// and the controller FSM state encoding.
package instr_fetch_ctrl_pkg;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [19:0] operand;
  } instruction_s;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Loader and instruction-memory bus of the fetch controller. The controller
// side is the master modport; the loader/memory environment is the slave.
interface instr_fetch_ctrl_if #(
  parameter int addr_width_p = 10
) ();
  import instr_fetch_ctrl_pkg::*;

  // Loader handshake: a word transfers in a cycle where load_valid_i and
  // load_ready_o are both high; load_valid_i and its payload must be held
  // until that cycle. load_ready_o is high only while loading.
  logic                    load_valid_i;
  logic [addr_width_p-1:0] load_addr_i;
  instruction_s            load_instr_i;
  logic                    load_done_i;
  logic                    load_ready_o;

  logic [addr_width_p-1:0] imem_addr_o;
  instruction_s            imem_instr_o;
  logic                    imem_wen_o;
  logic                    imem_nop_o;

  modport master (
    input  load_valid_i, load_addr_i, load_instr_i, load_done_i,
    output load_ready_o, imem_addr_o, imem_instr_o, imem_wen_o, imem_nop_o
  );

  modport slave (
    output load_valid_i, load_addr_i, load_instr_i, load_done_i,
    input  load_ready_o, imem_addr_o, imem_instr_o, imem_wen_o, imem_nop_o
  );

endinterface

// File: rtl/instr_fetch_ctrl.sv
// Fetch controller: loads a program into a synchronous instruction memory,
// then streams PCs to it with stall, branch-squash and halt control.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int addr_width_p = 10
) (
  input  logic                    clk,
  input  logic                    reset_n,
  instr_fetch_ctrl_if.master      bus,
  input  logic                    start_i,
  input  logic [addr_width_p-1:0] start_pc_i,
  input  logic                    stall_i,
  input  logic                    halt_i,
  input  logic                    branch_taken_i,
  input  logic [addr_width_p-1:0] branch_target_i,
  output logic [addr_width_p-1:0] fetch_pc_o,
  output logic                    fetch_valid_o,
  output ctrl_state_e             state_o,
  output logic [addr_width_p:0]   load_count_o
);

  localparam logic [addr_width_p:0]   depth_lp  = {1'b1, {addr_width_p{1'b0}}};
  localparam logic [addr_width_p:0]   cnt_one_lp = 1;
  localparam logic [addr_width_p-1:0] pc_one_lp  = 1;

  ctrl_state_e             state_q, state_d;
  logic [addr_width_p-1:0] pc_q, pc_d;
  logic [addr_width_p:0]   count_q, count_d;
  logic [addr_width_p-1:0] fetch_pc_q;
  logic                    fetch_valid_q;

  logic                    load_ready;
  logic                    wen;
  logic                    nop;
  logic [addr_width_p-1:0] addr;
  instruction_s            instr;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    load_ready = 1'b0;
    wen        = 1'b0;
    nop        = 1'b1;
    addr       = pc_q;
    instr      = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.load_valid_i) begin
          state_d = LOAD;
          count_d = '0;
        end else if (start_i) begin
          state_d = RUN;
          pc_d    = start_pc_i;
        end
      end
      LOAD: begin
        load_ready = 1'b1;
        if (bus.load_valid_i) begin
          wen   = 1'b1;
          nop   = 1'b0;
          addr  = bus.load_addr_i;
          instr = bus.load_instr_i;
          if (count_q != depth_lp) count_d = count_q + cnt_one_lp;
        end
        if (bus.load_done_i) state_d = IDLE;
      end
      RUN: begin
        nop = 1'b0;
        // halt beats branch beats stall; squashed slots drive nop
        if (halt_i) begin
          nop     = 1'b1;
          state_d = HALT;
        end else if (branch_taken_i) begin
          nop  = 1'b1;
          pc_d = branch_target_i;
        end else if (!stall_i) begin
          pc_d = pc_q + pc_one_lp;
        end
      end
      HALT: begin
        if (start_i) begin
          state_d = RUN;
          pc_d    = start_pc_i;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      count_q       <= '0;
      fetch_pc_q    <= '0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      count_q       <= count_d;
      // memory output lags its address by one cycle
      fetch_pc_q    <= addr;
      fetch_valid_q <= (state_q == RUN) && !nop;
    end
  end

  assign bus.load_ready_o = load_ready;
  assign bus.imem_wen_o   = wen;
  assign bus.imem_nop_o   = nop;
  assign bus.imem_addr_o  = addr;
  assign bus.imem_instr_o = instr;
  assign fetch_pc_o       = fetch_pc_q;
  assign fetch_valid_o    = fetch_valid_q;
  assign state_o          = state_q;
  assign load_count_o     = count_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios on a 10-bit and
// a 4-bit instance, then randomized traffic against a behavioural model.
module tb_instr_fetch_ctrl;
  import instr_fetch_ctrl_pkg::*;

  localparam int AW     = 10;
  localparam int SAW    = 4;
  localparam int DEPTH  = 1 << AW;
  localparam int SDEPTH = 1 << SAW;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [AW-1:0] exp_q[$];

  logic          start_i, stall_i, halt_i, branch_taken_i;
  logic [AW-1:0] start_pc_i, branch_target_i, fetch_pc_o;
  logic          fetch_valid_o;
  ctrl_state_e   state_o;
  logic [AW:0]   load_count_o;
  instr_fetch_ctrl_if #(.addr_width_p(AW)) bus ();

  instr_fetch_ctrl #(.addr_width_p(AW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .start_i(start_i), .start_pc_i(start_pc_i), .stall_i(stall_i), .halt_i(halt_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .fetch_pc_o(fetch_pc_o), .fetch_valid_o(fetch_valid_o),
    .state_o(state_o), .load_count_o(load_count_o)
  );

  logic           s_start_i, s_stall_i, s_halt_i, s_branch_taken_i;
  logic [SAW-1:0] s_start_pc_i, s_branch_target_i, s_fetch_pc_o;
  logic           s_fetch_valid_o;
  ctrl_state_e    s_state_o;
  logic [SAW:0]   s_load_count_o;
  instr_fetch_ctrl_if #(.addr_width_p(SAW)) sbus ();

  instr_fetch_ctrl #(.addr_width_p(SAW)) sdut (
    .clk(clk), .reset_n(reset_n), .bus(sbus),
    .start_i(s_start_i), .start_pc_i(s_start_pc_i), .stall_i(s_stall_i), .halt_i(s_halt_i),
    .branch_taken_i(s_branch_taken_i), .branch_target_i(s_branch_target_i),
    .fetch_pc_o(s_fetch_pc_o), .fetch_valid_o(s_fetch_valid_o),
    .state_o(s_state_o), .load_count_o(s_load_count_o)
  );

  // ---------------- clock/reset and driver tasks ----------------
  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start_i = 0; stall_i = 0; halt_i = 0; branch_taken_i = 0;
    start_pc_i = '0; branch_target_i = '0;
    bus.load_valid_i = 0; bus.load_addr_i = '0; bus.load_instr_i = '0; bus.load_done_i = 0;
    s_start_i = 0; s_stall_i = 0; s_halt_i = 0; s_branch_taken_i = 0;
    s_start_pc_i = '0; s_branch_target_i = '0;
    sbus.load_valid_i = 0; sbus.load_addr_i = '0; sbus.load_instr_i = '0; sbus.load_done_i = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset_n = 0;
    to_pos();
    to_pos();
    reset_n = 1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    bus.load_valid_i = 1; start_i = 1; start_pc_i = 10'd3;
    reset_n = 0;
    #1;
    checks++; if (state_o !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", state_o, IDLE); end
    checks++; if (bus.imem_wen_o !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b want 0", bus.imem_wen_o); end
    checks++; if (bus.imem_nop_o !== 1'b1) begin errors++; $display("FAIL reset_nop: got %b want 1", bus.imem_nop_o); end
    checks++; if (bus.imem_addr_o !== '0) begin errors++; $display("FAIL reset_addr: got %0d want 0", bus.imem_addr_o); end
    checks++; if (bus.imem_instr_o !== '0) begin errors++; $display("FAIL reset_instr: got %h want 0", bus.imem_instr_o); end
    checks++; if (bus.load_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.load_ready_o); end
    checks++; if (load_count_o !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", load_count_o); end
    checks++; if (fetch_pc_o !== '0) begin errors++; $display("FAIL reset_fetch_pc: got %0d want 0", fetch_pc_o); end
    checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL reset_fetch_valid: got %b want 0", fetch_valid_o); end
    to_pos();
    checks++; if (state_o !== IDLE) begin errors++; $display("FAIL reset_held: got %0d want %0d", state_o, IDLE); end
    bus.load_valid_i = 0;
    reset_n = 1;
    #1;
    checks++; if (state_o !== IDLE) begin errors++; $display("FAIL reset_release_state: got %0d want %0d", state_o, IDLE); end
    to_pos();
    checks++; if (state_o !== RUN) begin errors++; $display("FAIL reset_first_edge: got %0d want %0d", state_o, RUN); end
    checks++; if (bus.imem_addr_o !== 10'd3) begin errors++; $display("FAIL reset_first_pc: got %0d want 3", bus.imem_addr_o); end
    apply_reset();
  endtask

  task automatic test_load();
    instruction_s w;
    int pulses;
    pulses = 0;
    clear_inputs();
    bus.load_valid_i = 1; bus.load_addr_i = '0; bus.load_instr_i = instruction_s'($urandom);
    to_neg();
    checks++; if (bus.imem_wen_o !== 1'b0 || bus.load_ready_o !== 1'b0) begin errors++; $display("FAIL load_idle_no_write: got wen=%b ready=%b want 0 0", bus.imem_wen_o, bus.load_ready_o); end
    to_pos();
    checks++; if (state_o !== LOAD || load_count_o !== '0) begin errors++; $display("FAIL load_enter: got state=%0d count=%0d want %0d 0", state_o, load_count_o, LOAD); end
    for (int k = 0; k < 4; k++) begin
      w = instruction_s'($urandom);
      bus.load_addr_i = AW'(k); bus.load_instr_i = w; bus.load_done_i = (k == 3);
      to_neg();
      if (bus.imem_wen_o === 1'b1) pulses++;
      checks++; if (bus.imem_addr_o !== AW'(k) || bus.imem_instr_o !== w) begin errors++; $display("FAIL load_word%0d: got addr=%0d instr=%h want %0d %h", k, bus.imem_addr_o, bus.imem_instr_o, k, w); end
      checks++; if (bus.load_ready_o !== 1'b1 || bus.imem_nop_o !== 1'b0) begin errors++; $display("FAIL load_ctrl%0d: got ready=%b nop=%b want 1 0", k, bus.load_ready_o, bus.imem_nop_o); end
      to_pos();
    end
    clear_inputs();
    checks++; if (pulses != 4) begin errors++; $display("FAIL load_pulses: got %0d want 4", pulses); end
    checks++; if (load_count_o !== 11'd4) begin errors++; $display("FAIL load_count: got %0d want 4", load_count_o); end
    checks++; if (state_o !== IDLE) begin errors++; $display("FAIL load_done_state: got %0d want %0d", state_o, IDLE); end
    to_neg();
    checks++; if (bus.imem_wen_o !== 1'b0 || bus.imem_nop_o !== 1'b1) begin errors++; $display("FAIL load_after: got wen=%b nop=%b want 0 1", bus.imem_wen_o, bus.imem_nop_o); end
    to_pos();
  endtask

  task automatic test_run_sequence();
    logic [AW-1:0] e;
    exp_q.delete();
    start_i = 1; start_pc_i = '0;
    to_pos();
    start_i = 0;
    checks++; if (state_o !== RUN) begin errors++; $display("FAIL run_enter: got %0d want %0d", state_o, RUN); end
    for (int i = 0; i < 4; i++) begin
      to_neg();
      checks++; if (bus.imem_addr_o !== AW'(i) || bus.imem_nop_o !== 1'b0) begin errors++; $display("FAIL run_addr%0d: got addr=%0d nop=%b want %0d 0", i, bus.imem_addr_o, bus.imem_nop_o, i); end
      if (i == 0) begin
        checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL run_first_valid: got %b want 0", fetch_valid_o); end
      end else begin
        e = exp_q.pop_front();
        checks++; if (fetch_valid_o !== 1'b1 || fetch_pc_o !== e) begin errors++; $display("FAIL run_fetch%0d: got pc=%0d v=%b want %0d 1", i, fetch_pc_o, fetch_valid_o, e); end
      end
      exp_q.push_back(AW'(i));
      to_pos();
    end
    halt_i = 1;
    to_neg();
    e = exp_q.pop_front();
    checks++; if (fetch_valid_o !== 1'b1 || fetch_pc_o !== e) begin errors++; $display("FAIL run_fetch_last: got pc=%0d v=%b want %0d 1", fetch_pc_o, fetch_valid_o, e); end
    checks++; if (bus.imem_nop_o !== 1'b1) begin errors++; $display("FAIL run_halt_nop: got %b want 1", bus.imem_nop_o); end
    to_pos();
    halt_i = 0;
    checks++; if (state_o !== HALT) begin errors++; $display("FAIL run_halt_state: got %0d want %0d", state_o, HALT); end
    to_neg();
    checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL run_halt_valid: got %b want 0", fetch_valid_o); end
    to_pos();
  endtask

  task automatic test_stall();
    start_i = 1; start_pc_i = 10'd5;
    to_pos();
    start_i = 0;
    for (int c = 0; c < 3; c++) begin
      stall_i = (c < 2);
      to_neg();
      checks++; if (bus.imem_addr_o !== 10'd5 || bus.imem_nop_o !== 1'b0) begin errors++; $display("FAIL stall_hold%0d: got addr=%0d nop=%b want 5 0", c, bus.imem_addr_o, bus.imem_nop_o); end
      to_pos();
    end
    stall_i = 0;
    to_neg();
    checks++; if (bus.imem_addr_o !== 10'd6 || fetch_pc_o !== 10'd5 || fetch_valid_o !== 1'b1) begin errors++; $display("FAIL stall_resume: got addr=%0d fpc=%0d v=%b want 6 5 1", bus.imem_addr_o, fetch_pc_o, fetch_valid_o); end
    to_pos();
  endtask

  task automatic test_branch();
    halt_i = 1;
    to_pos();
    halt_i = 0; start_i = 1; start_pc_i = 10'd7;
    to_pos();
    start_i = 0; branch_taken_i = 1; stall_i = 1; branch_target_i = 10'd20;
    to_neg();
    checks++; if (bus.imem_nop_o !== 1'b1 || bus.imem_wen_o !== 1'b0 || bus.imem_addr_o !== 10'd7) begin errors++; $display("FAIL branch_squash: got nop=%b wen=%b addr=%0d want 1 0 7", bus.imem_nop_o, bus.imem_wen_o, bus.imem_addr_o); end
    to_pos();
    branch_taken_i = 0; stall_i = 0;
    to_neg();
    checks++; if (bus.imem_addr_o !== 10'd20 || bus.imem_nop_o !== 1'b0) begin errors++; $display("FAIL branch_target: got addr=%0d nop=%b want 20 0", bus.imem_addr_o, bus.imem_nop_o); end
    checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL branch_slot_valid: got %b want 0", fetch_valid_o); end
    to_pos();
    to_neg();
    checks++; if (fetch_valid_o !== 1'b1 || fetch_pc_o !== 10'd20 || bus.imem_addr_o !== 10'd21) begin errors++; $display("FAIL branch_follow: got fpc=%0d v=%b addr=%0d want 20 1 21", fetch_pc_o, fetch_valid_o, bus.imem_addr_o); end
    to_pos();
  endtask

  task automatic test_halt();
    logic [AW-1:0] spc;
    halt_i = 1; branch_taken_i = 1; stall_i = 1; branch_target_i = 10'd99;
    to_neg();
    checks++; if (bus.imem_nop_o !== 1'b1 || bus.imem_addr_o !== 10'd22) begin errors++; $display("FAIL halt_cycle: got nop=%b addr=%0d want 1 22", bus.imem_nop_o, bus.imem_addr_o); end
    to_pos();
    clear_inputs();
    checks++; if (state_o !== HALT) begin errors++; $display("FAIL halt_priority: got %0d want %0d", state_o, HALT); end
    for (int c = 0; c < 3; c++) begin
      to_neg();
      checks++; if (bus.imem_nop_o !== 1'b1 || bus.imem_addr_o !== 10'd22 || fetch_valid_o !== 1'b0 || state_o !== HALT) begin errors++; $display("FAIL halt_frozen%0d: got nop=%b addr=%0d v=%b st=%0d want 1 22 0 %0d", c, bus.imem_nop_o, bus.imem_addr_o, fetch_valid_o, state_o, HALT); end
      to_pos();
    end
    spc = AW'($urandom_range(100, DEPTH - 1));
    start_i = 1; start_pc_i = spc;
    to_pos();
    start_i = 0;
    to_neg();
    checks++; if (state_o !== RUN || bus.imem_addr_o !== spc || bus.imem_nop_o !== 1'b0) begin errors++; $display("FAIL halt_restart: got st=%0d addr=%0d nop=%b want %0d %0d 0", state_o, bus.imem_addr_o, bus.imem_nop_o, RUN, spc); end
    to_pos();
  endtask

  task automatic test_small_dut();
    sbus.load_valid_i = 1;
    to_pos();
    for (int k = 0; k < 20; k++) begin
      sbus.load_addr_i = SAW'(k % SDEPTH); sbus.load_instr_i = instruction_s'($urandom);
      sbus.load_done_i = (k == 19);
      to_pos();
      if (k == 15) begin
        checks++; if (s_load_count_o !== 5'd16) begin errors++; $display("FAIL small_count_full: got %0d want 16", s_load_count_o); end
      end
    end
    clear_inputs();
    checks++; if (s_load_count_o !== 5'd16 || s_state_o !== IDLE) begin errors++; $display("FAIL small_count_sat: got %0d st=%0d want 16 %0d", s_load_count_o, s_state_o, IDLE); end
    s_start_i = 1; s_start_pc_i = 4'd15;
    to_pos();
    s_start_i = 0;
    to_neg();
    checks++; if (sbus.imem_addr_o !== 4'd15) begin errors++; $display("FAIL small_top: got %0d want 15", sbus.imem_addr_o); end
    to_pos();
    to_neg();
    checks++; if (sbus.imem_addr_o !== 4'd0 || s_fetch_pc_o !== 4'd15 || s_fetch_valid_o !== 1'b1) begin errors++; $display("FAIL small_wrap: got addr=%0d fpc=%0d v=%b want 0 15 1", sbus.imem_addr_o, s_fetch_pc_o, s_fetch_valid_o); end
    to_pos();
    s_halt_i = 1;
    to_neg();
    checks++; if (sbus.imem_nop_o !== 1'b1) begin errors++; $display("FAIL small_halt_nop: got %b want 1", sbus.imem_nop_o); end
    to_pos();
    s_halt_i = 0;
    for (int c = 0; c < 3; c++) begin
      to_neg();
      checks++; if (sbus.imem_nop_o !== 1'b1 || s_state_o !== HALT) begin errors++; $display("FAIL small_halted%0d: got nop=%b st=%0d want 1 %0d", c, sbus.imem_nop_o, s_state_o, HALT); end
      to_pos();
    end
  endtask

  task automatic test_reset_mid_load();
    apply_reset();
    bus.load_valid_i = 1;
    to_pos();
    for (int k = 0; k < 2; k++) begin
      bus.load_addr_i = AW'(k + 40); bus.load_instr_i = instruction_s'($urandom);
      to_pos();
    end
    bus.load_addr_i = 10'd9;
    to_neg();
    checks++; if (bus.imem_wen_o !== 1'b1 || load_count_o !== 11'd2) begin errors++; $display("FAIL midload_pre: got wen=%b count=%0d want 1 2", bus.imem_wen_o, load_count_o); end
    #1 reset_n = 0;
    #1;
    checks++; if (bus.imem_wen_o !== 1'b0 || bus.load_ready_o !== 1'b0 || bus.imem_nop_o !== 1'b1) begin errors++; $display("FAIL midload_abort: got wen=%b ready=%b nop=%b want 0 0 1", bus.imem_wen_o, bus.load_ready_o, bus.imem_nop_o); end
    checks++; if (state_o !== IDLE || load_count_o !== '0 || bus.imem_addr_o !== '0) begin errors++; $display("FAIL midload_state: got st=%0d count=%0d addr=%0d want %0d 0 0", state_o, load_count_o, bus.imem_addr_o, IDLE); end
    to_pos();
    clear_inputs();
    reset_n = 1;
    start_i = 1; start_pc_i = 10'd300;
    to_pos();
    start_i = 0;
    to_pos();
    to_pos();
    #2 reset_n = 0;
    #1;
    checks++; if (state_o !== IDLE || fetch_pc_o !== '0 || bus.imem_addr_o !== '0 || fetch_valid_o !== 1'b0) begin errors++; $display("FAIL midrun_reset: got st=%0d fpc=%0d addr=%0d v=%b want %0d 0 0 0", state_o, fetch_pc_o, bus.imem_addr_o, fetch_valid_o, IDLE); end
    to_pos();
    reset_n = 1;
  endtask

  // Randomized traffic; model tracks the controller as mode + PC + count.
  task automatic test_random();
    ctrl_state_e m_st;
    int m_pc, m_cnt, m_fpc, e_addr;
    bit m_fv, e_wen, e_nop;
    instruction_s e_instr;
    apply_reset();
    m_st = IDLE; m_pc = 0; m_cnt = 0; m_fpc = 0; m_fv = 0;
    for (int n = 0; n < 400; n++) begin
      bus.load_valid_i = ($urandom_range(0, 9) < 3);
      bus.load_addr_i  = AW'($urandom);
      bus.load_instr_i = instruction_s'($urandom);
      bus.load_done_i  = ($urandom_range(0, 9) < 2);
      start_i          = ($urandom_range(0, 9) < 3);
      start_pc_i       = AW'($urandom);
      stall_i          = ($urandom_range(0, 9) < 2);
      halt_i           = ($urandom_range(0, 19) == 0);
      branch_taken_i   = ($urandom_range(0, 19) < 3);
      branch_target_i  = AW'($urandom);
      e_wen   = (m_st == LOAD) && bus.load_valid_i;
      e_nop   = (m_st == RUN) ? (halt_i || branch_taken_i) : !e_wen;
      e_addr  = e_wen ? int'(bus.load_addr_i) : m_pc;
      e_instr = e_wen ? bus.load_instr_i : '0;
      to_neg();
      checks++; if (state_o !== m_st) begin errors++; $display("FAIL rnd_state@%0d: got %0d want %0d", n, state_o, m_st); end
      checks++; if (bus.imem_wen_o !== e_wen || bus.imem_nop_o !== e_nop) begin errors++; $display("FAIL rnd_wen_nop@%0d: got %b %b want %b %b", n, bus.imem_wen_o, bus.imem_nop_o, e_wen, e_nop); end
      checks++; if (bus.imem_wen_o === 1'b1 && bus.imem_nop_o === 1'b1) begin errors++; $display("FAIL rnd_exclusive@%0d: got wen=1 nop=1 want not both", n); end
      checks++; if (bus.imem_addr_o !== AW'(e_addr) || bus.imem_instr_o !== e_instr) begin errors++; $display("FAIL rnd_bus@%0d: got %0d %h want %0d %h", n, bus.imem_addr_o, bus.imem_instr_o, e_addr, e_instr); end
      checks++; if (bus.load_ready_o !== (m_st == LOAD) || load_count_o !== (AW + 1)'(m_cnt)) begin errors++; $display("FAIL rnd_load@%0d: got ready=%b cnt=%0d want %b %0d", n, bus.load_ready_o, load_count_o, m_st == LOAD, m_cnt); end
      checks++; if (fetch_valid_o !== m_fv || fetch_pc_o !== AW'(m_fpc)) begin errors++; $display("FAIL rnd_fetch@%0d: got %0d v=%b want %0d v=%b", n, fetch_pc_o, fetch_valid_o, m_fpc, m_fv); end
      to_pos();
      m_fpc = e_addr;
      m_fv  = (m_st == RUN) && !e_nop;
      case (m_st)
        IDLE: if (bus.load_valid_i) begin m_st = LOAD; m_cnt = 0; end
              else if (start_i) begin m_st = RUN; m_pc = int'(start_pc_i); end
        LOAD: begin
          if (e_wen) m_cnt = (m_cnt < DEPTH) ? m_cnt + 1 : DEPTH;
          if (bus.load_done_i) m_st = IDLE;
        end
        RUN: if (halt_i) m_st = HALT;
             else if (branch_taken_i) m_pc = int'(branch_target_i);
             else if (!stall_i) m_pc = (m_pc + 1) % DEPTH;
        default: if (start_i) begin m_st = RUN; m_pc = int'(start_pc_i); end
      endcase
    end
    clear_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 0;
    clear_inputs();
    #12;
    test_reset();
    test_load();
    test_run_sequence();
    test_stall();
    test_branch();
    test_halt();
    test_small_dut();
    test_reset_mid_load();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
